// File: rtl/neural_pkg.sv
// Shared types and constants for the layer engine: FSM encoding, activation
// mode values and the accumulator width rule.
package neural_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_MAC,
    ST_ACT,
    ST_DONE
  } state_t;

  localparam logic ACT_MODE_RELU   = 1'b0;
  localparam logic ACT_MODE_LINEAR = 1'b1;

  // Headroom of clog2(n) bits lets n full-scale products sum without overflow.
  function automatic int acc_width(input int data_w, input int weight_w, input int n);
    return data_w + weight_w + $clog2(n);
  endfunction

endpackage

// File: rtl/neural_mac_unit.sv
// One neuron: signed multiply-accumulate plus the shift / ReLU / saturate
// activation applied to the running accumulator.
module neural_mac_unit
  import neural_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int WEIGHT_W  = 8,
  parameter int FRAC_BITS = 4,
  parameter int ACC_W     = 26
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic                       relu,
  input  logic signed [DATA_W-1:0]   x,
  input  logic signed [WEIGHT_W-1:0] w,
  output logic signed [DATA_W-1:0]   y
);

  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [ACC_W-1:0]  clipped;

  assign prod = x * w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  end

  // Arithmetic shift floors toward -inf, which is the intended rounding.
  assign shifted = acc >>> FRAC_BITS;

  always_comb begin
    clipped = shifted;
    if (relu && shifted < 0) clipped = '0;
    else if (shifted > MAXV) clipped = MAXV;
    else if (shifted < MINV) clipped = MINV;
  end

  assign y = clipped[DATA_W-1:0];

endmodule

// File: rtl/neural_layer_engine.sv
// Multi-layer dense evaluator: NUM_UNITS neurons in parallel, one input per
// cycle streamed from an external weight ROM, results fed back as next inputs.
module neural_layer_engine
  import neural_pkg::*;
#(
  parameter int NUM_UNITS  = 4,
  parameter int NUM_LAYERS = 3,
  parameter int DATA_W     = 16,
  parameter int WEIGHT_W   = 8,
  parameter int FRAC_BITS  = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    act_mode,
  input  logic                                    in_we,
  input  logic [$clog2(NUM_UNITS)-1:0]            in_addr,
  input  logic [DATA_W-1:0]                       in_data,
  output logic [$clog2(NUM_LAYERS*NUM_UNITS)-1:0] w_addr,
  input  logic [NUM_UNITS*WEIGHT_W-1:0]           w_data,
  output logic                                    busy,
  output logic                                    done,
  output logic [NUM_UNITS*DATA_W-1:0]             out_data
);

  localparam int ACC_W  = acc_width(DATA_W, WEIGHT_W, NUM_UNITS);
  localparam int IDX_W  = $clog2(NUM_UNITS);
  localparam int ADDR_W = $clog2(NUM_LAYERS*NUM_UNITS);
  localparam int LYR_W  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_UNITS-1);
  localparam logic [LYR_W-1:0]  LAST_LAYER = LYR_W'(NUM_LAYERS-1);
  localparam logic [ADDR_W-1:0] UNITS_A    = ADDR_W'(NUM_UNITS);

  state_t                             state;
  logic [LYR_W-1:0]                   layer;
  logic [IDX_W-1:0]                   idx;
  logic                               mode_q;
  logic [NUM_UNITS-1:0][DATA_W-1:0]   data_q;
  logic [NUM_UNITS-1:0][DATA_W-1:0]   act_y;
  logic [ADDR_W-1:0]                  base_addr;
  logic                               acc_clr;
  logic                               acc_en;

  assign busy      = (state != ST_IDLE);
  assign base_addr = ADDR_W'(layer) * UNITS_A;
  assign acc_en    = (state == ST_MAC);
  assign acc_clr   = (state == ST_IDLE && start) || (state == ST_ACT && layer != LAST_LAYER);

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    neural_mac_unit #(
      .DATA_W   (DATA_W),
      .WEIGHT_W (WEIGHT_W),
      .FRAC_BITS(FRAC_BITS),
      .ACC_W    (ACC_W)
    ) u_mac (
      .clk (clk),
      .rst (reset),
      .clr (acc_clr),
      .en  (acc_en),
      .relu(mode_q == ACT_MODE_RELU),
      .x   (data_q[idx]),
      .w   (w_data[u*WEIGHT_W +: WEIGHT_W]),
      .y   (act_y[u])
    );
  end

  // w_addr is registered one step ahead of the index being accumulated,
  // since the ROM answers one cycle after the address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      layer    <= '0;
      idx      <= '0;
      mode_q   <= ACT_MODE_RELU;
      data_q   <= '0;
      w_addr   <= '0;
      done     <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          w_addr <= '0;
          if (in_we) data_q[in_addr] <= in_data;
          if (start) begin
            state  <= ST_FETCH;
            layer  <= '0;
            idx    <= '0;
            mode_q <= act_mode;
          end
        end
        ST_FETCH: begin
          w_addr <= base_addr + ADDR_W'(1);
          state  <= ST_MAC;
        end
        ST_MAC: begin
          if (idx == LAST_IDX) begin
            idx    <= '0;
            w_addr <= '0;
            state  <= ST_ACT;
          end else begin
            idx    <= idx + IDX_W'(1);
            w_addr <= (idx < IDX_W'(NUM_UNITS-2)) ? base_addr + ADDR_W'(idx) + ADDR_W'(2) : '0;
          end
        end
        ST_ACT: begin
          data_q <= act_y;
          if (layer == LAST_LAYER) begin
            out_data <= act_y;
            done     <= 1'b1;
            w_addr   <= '0;
            state    <= ST_DONE;
          end else begin
            layer  <= layer + LYR_W'(1);
            w_addr <= base_addr + UNITS_A;
            state  <= ST_FETCH;
          end
        end
        ST_DONE: begin
          done   <= 1'b0;
          w_addr <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neural_layer_engine.sv
// Directed-vector bench for neural_layer_engine with a synchronous weight ROM model.
module tb_neural_layer_engine;

  localparam int N = 4;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        act_mode = 1'b0;
  logic        in_we = 1'b0;
  logic [1:0]  in_addr = '0;
  logic [15:0] in_data = '0;
  logic [3:0]  w_addr;
  logic [31:0] w_data = '0;
  logic        busy;
  logic        done;
  logic [63:0] out_data;

  logic [31:0] rom [L*N];

  int n_vec = 0;
  int n_bad = 0;

  logic busy_log [0:39];
  logic done_log [0:39];
  int   wa_log   [0:39];

  always #5 clk = ~clk;

  always @(posedge clk) w_data <= rom[w_addr];

  neural_layer_engine #(
    .NUM_UNITS(N), .NUM_LAYERS(L), .DATA_W(16), .WEIGHT_W(8), .FRAC_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .act_mode(act_mode),
    .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
    .w_addr(w_addr), .w_data(w_data), .busy(busy), .done(done), .out_data(out_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic set_diag(input logic [7:0] d);
    logic [31:0] row;
    for (int l = 0; l < L; l++)
      for (int i = 0; i < N; i++) begin
        row = '0;
        row[i*8 +: 8] = d;
        rom[l*N+i] = row;
      end
  endtask

  task automatic set_all(input logic [7:0] w);
    for (int k = 0; k < L*N; k++) rom[k] = {4{w}};
  endtask

  task automatic load(input int a, input int b, input int c, input int d);
    int v [4];
    v = '{a, b, c, d};
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      in_we = 1'b1; in_addr = 2'(k); in_data = 16'(v[k]);
    end
    @(negedge clk);
    in_we = 1'b0;
  endtask

  // Cycle c is sampled 1 ns after the c-th edge, counting the start-sampling edge as 1.
  task automatic run(input logic mode, input logic inject);
    @(negedge clk);
    act_mode = mode; start = 1'b1;
    for (int c = 1; c < 40; c++) begin
      @(posedge clk); #1;
      busy_log[c] = busy; done_log[c] = done; wa_log[c] = int'(w_addr);
      @(negedge clk);
      start = 1'b0; in_we = 1'b0;
      if (inject && (c == 2 || c == 9)) begin
        start = 1'b1; in_we = 1'b1; in_addr = 2'd3; in_data = 16'd999;
      end
    end
  endtask

  task automatic chk_timing(input string tag);
    int dn = 0, first = 0, bz = 0;
    for (int c = 1; c < 40; c++) begin
      if (done_log[c]) begin dn++; if (first == 0) first = c; end
      if (busy_log[c]) bz++;
    end
    chk({tag, "_done_cnt"}, 64'(dn), 64'd1);
    chk({tag, "_done_cyc"}, 64'(first), 64'd19);
    chk({tag, "_busy_cnt"}, 64'(bz), 64'd19);
    chk({tag, "_busy_c1"}, 64'(busy_log[1]), 64'd1);
    chk({tag, "_busy_c20"}, 64'(busy_log[20]), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out", out_data, 64'd0);
    chk("rst_waddr", 64'(w_addr), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // identity
    set_diag(8'd16);
    load(10, 20, 30, 40);
    run(1'b0, 1'b0);
    chk("ident_out", out_data, pk4(10, 20, 30, 40));
    chk_timing("ident");
    chk("ident_waddr_done", 64'(wa_log[19]), 64'd0);
    chk("ident_waddr_idle", 64'(wa_log[25]), 64'd0);

    // protocol: stray start/in_we mid-run
    load(10, 20, 30, 40);
    run(1'b0, 1'b1);
    chk("proto_out", out_data, pk4(10, 20, 30, 40));
    chk_timing("proto");
    for (int l = 0; l < L; l++)
      for (int k = 0; k < N; k++)
        chk($sformatf("proto_waddr_c%0d", 1 + 6*l + k), 64'(wa_log[1 + 6*l + k]), 64'(4*l + k));

    // activation modes
    set_diag(8'hF0);
    load(5, 5, 5, 5);
    run(1'b0, 1'b0);
    chk("relu_neg_out", out_data, pk4(0, 0, 0, 0));
    load(5, 5, 5, 5);
    run(1'b1, 1'b0);
    chk("lin_neg_out", out_data, pk4(-5, -5, -5, -5));
    // data registers keep -5 from the last layer; odd layer count flips sign
    run(1'b1, 1'b0);
    chk("retain_out", out_data, pk4(5, 5, 5, 5));

    // saturation
    set_all(8'd127);
    load(32767, 32767, 32767, 32767);
    run(1'b1, 1'b0);
    chk("sat_pos_out", out_data, pk4(32767, 32767, 32767, 32767));
    load(-32768, -32768, -32768, -32768);
    run(1'b1, 1'b0);
    chk("sat_neg_out", out_data, pk4(-32768, -32768, -32768, -32768));
    chk_timing("sat");

    // reset mid-run at cycle 5
    set_diag(8'd16);
    @(negedge clk);
    act_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_out", out_data, 64'd0);
    chk("mrst_waddr", 64'(w_addr), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    load(10, 20, 30, 40);
    run(1'b0, 1'b0);
    chk("mrst_ident_out", out_data, pk4(10, 20, 30, 40));
    chk_timing("mrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/neural_layer_engine.md
NEURAL_LAYER_ENGINE -- requirements
Module: neural_layer_engine

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4, meaning neurons per layer and inputs per neuron (>=2).
REQ-002 SHALL have parameter NUM_LAYERS, default 3, meaning layers evaluated per run (>=1).
REQ-003 SHALL have parameter DATA_W, default 16, meaning signed activation width.
REQ-004 SHALL have parameter WEIGHT_W, default 8, meaning signed weight width.
REQ-005 SHALL have parameter FRAC_BITS, default 4, meaning weight fractional bits (16 = 1.0 at default).
REQ-006 SHALL use one clock and an asynchronous active-high reset: clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 start  in  1  one-cycle run request.
REQ-009 act_mode  in  1  0 = ReLU+saturate, 1 = linear+saturate; sampled with start.
REQ-010 in_we  in  1  write one input activation.
REQ-011 in_addr  in  clog2(NUM_UNITS)  input slot index.
REQ-012 in_data  in  DATA_W  signed input activation.
REQ-013 w_addr  out  clog2(NUM_LAYERS*NUM_UNITS)  weight ROM address = layer*NUM_UNITS + i.
REQ-014 w_data  in  NUM_UNITS*WEIGHT_W  weight row; slice u = weight of input i to unit u; valid one cycle after w_addr.
REQ-015 busy  out  1  run in progress.
REQ-016 done  out  1  one-cycle pulse at run completion.
REQ-017 out_data  out  NUM_UNITS*DATA_W  final-layer outputs, slice u = unit u.

Function
REQ-018 FSM states IDLE, FETCH, MAC, ACT, DONE; busy = 1 in all but IDLE.
REQ-019 IDLE: start=1 -> FETCH, layer=0, i=0, latch act_mode, clear all accumulators; start ignored in every other state.
REQ-020 in_we=1 in IDLE writes in_data to data register in_addr; in_we ignored while busy.
REQ-021 FETCH (1 cycle) drives w_addr = layer*NUM_UNITS; -> MAC.
REQ-022 MAC (NUM_UNITS cycles): each unit u adds data[i]*w_data slice u to acc[u]; w_addr drives the next index; after i = NUM_UNITS-1 -> ACT.
REQ-023 Product width DATA_W+WEIGHT_W signed; accumulator ACC_W = DATA_W+WEIGHT_W+clog2(NUM_UNITS), never overflows.
REQ-024 ACT (1 cycle): r = acc >>> FRAC_BITS (arithmetic, floor); ReLU mode forces r<0 to 0; both modes saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; all NUM_UNITS results written to data registers simultaneously.
REQ-025 ACT, layer < NUM_LAYERS-1: layer+1, i=0, accumulators cleared -> FETCH; last layer: results also registered to out_data -> DONE.
REQ-026 DONE: done=1 for exactly one cycle -> IDLE.
REQ-027 Latency: done high exactly NUM_LAYERS*(NUM_UNITS+2)+1 cycles after the edge sampling start (19 at defaults).
REQ-028 out_data holds value until next run completion; data registers retain last layer outputs after run.
REQ-029 w_addr = 0 in IDLE and DONE.

Reset
REQ-030 reset asserted at any time (including mid-run): state IDLE, busy=0, done=0, out_data=0, data registers=0, accumulators=0, layer=0, i=0, w_addr=0, act_mode latch=0.
REQ-031 First start after reset deassertion SHALL produce a complete, correct run.

Structure
REQ-032 Shared package neural_pkg holds FSM state enum, ACT_MODE_RELU/ACT_MODE_LINEAR constants, ACC_W computation.
REQ-033 One sub-module neural_mac_unit (accumulator, multiply, shift/ReLU/saturate), instantiated NUM_UNITS times via generate.

Verification
REQ-034 Identity: x=[10,20,30,40], all layers diagonal weight 16, off-diagonal 0, ReLU -> out_data=[10,20,30,40], done at cycle 19, busy high cycles 1-19.
REQ-035 Modes: x=[5,5,5,5], all layers diagonal -16; ReLU -> [0,0,0,0]; linear -> [-5,-5,-5,-5].
REQ-036 Saturation: x all 32767, all weights 127, linear -> all 32767; x all -32768, weights 127, linear -> all -32768.
REQ-037 Protocol: start and in_we pulsed at cycles 3 and 10 of a run -> no restart, data unchanged, single done at cycle 19, w_addr sequence 0..3,4..7,8..11.
REQ-038 Reset mid-run at cycle 5 -> busy=0, done=0, out_data=0 immediately; re-load identity case, start -> REQ-034 result.
